// File: rtl/regfile_mp.sv
// Multi-port register file: r0 reads as zero, registered read ports with optional
// write-to-read forwarding, a self-clearing sequencer, and a saturating write-conflict counter.
module regfile_mp #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int BYPASS  = 1,
  parameter int DBG_IDX = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic                   stall,
  input  logic                   clr,
  input  logic [NRD*AW-1:0]      raddr,
  output logic [NRD*WIDTH-1:0]   rdata,
  input  logic [NWR-1:0]         wen,
  input  logic [NWR*AW-1:0]      waddr,
  input  logic [NWR*WIDTH-1:0]   wdata,
  output logic                   busy,
  output logic [7:0]             conflict_cnt,
  output logic [WIDTH-1:0]       ret_val
);

  // state | meaning
  // IDLE  | normal operation, write ports active
  // CLEAR | sweeping ptr over every register writing zero, writes ignored
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        ptr;
  logic [WIDTH-1:0]     mem [NREGS];
  logic                 commit;
  logic                 conflict;
  logic [NRD*WIDTH-1:0] rd_nxt;

  assign commit = clk_en && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else if (clk_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr) state_nxt = CLEAR;
      CLEAR:   if (ptr == AW'(NREGS - 1)) state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // ptr naturally wraps to 0 on the last clear, so IDLE always restarts from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (clk_en) begin
      if (state == CLEAR) ptr <= ptr + AW'(1);
      else if (clr)       ptr <= '0;
    end
  end

  // Later ports overwrite earlier ones via NBA ordering, giving the highest port priority.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (state == CLEAR) mem[ptr] <= '0;
      else begin
        for (int p = 0; p < NWR; p++) begin
          if (wen[p] && (waddr[p*AW +: AW] != '0))
            mem[waddr[p*AW +: AW]] <= wdata[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wen[i] && wen[j] && (waddr[i*AW +: AW] == waddr[j*AW +: AW]) &&
            (waddr[i*AW +: AW] != '0))
          conflict = 1'b1;
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    if (state == IDLE) begin
      for (int k = 0; k < NRD; k++) begin
        if (raddr[k*AW +: AW] != '0) begin
          rd_nxt[k*WIDTH +: WIDTH] = mem[raddr[k*AW +: AW]];
          if (BYPASS != 0) begin
            for (int p = 0; p < NWR; p++) begin
              if (wen[p] && (waddr[p*AW +: AW] == raddr[k*AW +: AW]))
                rd_nxt[k*WIDTH +: WIDTH] = wdata[p*WIDTH +: WIDTH];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (clk_en && !stall) rdata <= rd_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_cnt <= '0;
    else if (commit && conflict && (conflict_cnt != 8'hFF))
      conflict_cnt <= conflict_cnt + 8'd1;
  end

  generate
    if (DBG_IDX == 0) begin : g_ret_zero
      assign ret_val = '0;
    end else begin : g_ret_reg
      assign ret_val = mem[AW'(DBG_IDX)];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding instance and one non-forwarding instance
// share stimulus so same-cycle read/write behaviour can be compared side by side.
module tb_regfile_mp;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_en = 1'b1;
  logic          stall = 1'b0;
  logic          clr = 1'b0;
  logic [2*AW-1:0] raddr = '0;
  logic [2*W-1:0]  rdata, rdata_nb;
  logic [1:0]      wen = '0;
  logic [2*AW-1:0] waddr = '0;
  logic [2*W-1:0]  wdata = '0;
  logic            busy, busy_nb;
  logic [7:0]      conflict_cnt, conflict_cnt_nb;
  logic [W-1:0]    ret_val, ret_val_nb;

  int n_checks = 0;
  int n_fail = 0;

  regfile_mp #(.WIDTH(W), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .DBG_IDX(1)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall), .clr(clr),
    .raddr(raddr), .rdata(rdata), .wen(wen), .waddr(waddr), .wdata(wdata),
    .busy(busy), .conflict_cnt(conflict_cnt), .ret_val(ret_val));

  regfile_mp #(.WIDTH(W), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0), .DBG_IDX(1)) dut_nb (
    .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall), .clr(clr),
    .raddr(raddr), .rdata(rdata_nb), .wen(wen), .waddr(waddr), .wdata(wdata),
    .busy(busy_nb), .conflict_cnt(conflict_cnt_nb), .ret_val(ret_val_nb));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write0(input logic [AW-1:0] a, input logic [W-1:0] d);
    wen = 2'b01; waddr[AW-1:0] = a; wdata[W-1:0] = d;
    tick();
    wen = 2'b00;
  endtask

  task automatic read0(input logic [AW-1:0] a, output logic [W-1:0] d);
    raddr[AW-1:0] = a;
    tick();
    d = rdata[W-1:0];
  endtask

  task automatic wait_busy_low(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    int n;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b1 || rdata !== '0 || conflict_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b rdata=%h cnt=%0d, need busy=1 rdata=0 cnt=0", busy, rdata, conflict_cnt);
    end
    tick();
    rst = 1'b0;
    wait_busy_low(n);
    n_checks++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL reset_busy_len: %0d cycles, need 32", n);
    end
    for (int r = 0; r < 32; r++) begin
      read0(AW'(r), d);
      n_checks++;
      if (d !== '0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, need 0", r, d);
      end
    end
    n_checks++;
    if (ret_val !== '0) begin
      n_fail++;
      $display("FAIL reset_ret_val: got %h, need 0", ret_val);
    end
  endtask

  task automatic test_priority();
    logic [W-1:0] d;
    wen = 2'b11; waddr = {5'd5, 5'd5}; wdata = {32'h0000BBBB, 32'h0000AAAA};
    tick();
    wen = 2'b00;
    n_checks++;
    if (conflict_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL prio_conflict_cnt: got %0d, need 1", conflict_cnt);
    end
    read0(5'd5, d);
    n_checks++;
    if (d !== 32'h0000BBBB) begin
      n_fail++;
      $display("FAIL prio_reg5: got %h, need 0000bbbb", d);
    end
  endtask

  task automatic test_bypass();
    write0(5'd7, 32'h1111);
    raddr[AW-1:0] = 5'd7;
    wen = 2'b01; waddr[AW-1:0] = 5'd7; wdata[W-1:0] = 32'h1234;
    tick();
    wen = 2'b00;
    n_checks++;
    if (rdata[W-1:0] !== 32'h1234) begin
      n_fail++;
      $display("FAIL bypass_on: got %h, need 00001234", rdata[W-1:0]);
    end
    n_checks++;
    if (rdata_nb[W-1:0] !== 32'h1111) begin
      n_fail++;
      $display("FAIL bypass_off: got %h, need 00001111", rdata_nb[W-1:0]);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] d;
    write0(5'd3, 32'h10);
    read0(5'd3, d);
    n_checks++;
    if (d !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_pre: got %h, need 10", d);
    end
    stall = 1'b1;
    write0(5'd3, 32'h20);
    n_checks++;
    if (rdata[W-1:0] !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_hold1: got %h, need 10", rdata[W-1:0]);
    end
    tick();
    n_checks++;
    if (rdata[W-1:0] !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_hold2: got %h, need 10", rdata[W-1:0]);
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (rdata[W-1:0] !== 32'h20) begin
      n_fail++;
      $display("FAIL stall_release: got %h, need 20", rdata[W-1:0]);
    end
  endtask

  task automatic test_clk_en();
    logic [W-1:0] d;
    clk_en = 1'b0;
    raddr[AW-1:0] = 5'd4;
    write0(5'd4, 32'h99);
    n_checks++;
    if (rdata[W-1:0] !== 32'h20) begin
      n_fail++;
      $display("FAIL clk_en_hold: got %h, need 20", rdata[W-1:0]);
    end
    clk_en = 1'b1;
    read0(5'd4, d);
    n_checks++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL clk_en_nowrite: got %h, need 0", d);
    end
  endtask

  task automatic test_r0();
    write0(5'd1, 32'hCAFE);
    raddr[AW-1:0] = 5'd0;
    wen = 2'b11; waddr = {5'd0, 5'd0}; wdata = {32'hFFFF, 32'hFFFF};
    tick();
    wen = 2'b00;
    n_checks++;
    if (rdata[W-1:0] !== '0) begin
      n_fail++;
      $display("FAIL r0_read: got %h, need 0", rdata[W-1:0]);
    end
    n_checks++;
    if (ret_val !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL r0_ret_val: got %h, need 0000cafe", ret_val);
    end
    n_checks++;
    if (conflict_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL r0_conflict: got %0d, need 1", conflict_cnt);
    end
  endtask

  task automatic test_clr();
    logic [W-1:0] d;
    int n;
    write0(5'd9, 32'h55);
    read0(5'd9, d);
    n_checks++;
    if (d !== 32'h55) begin
      n_fail++;
      $display("FAIL clr_pre: got %h, need 55", d);
    end
    clr = 1'b1;
    wen = 2'b01; waddr[AW-1:0] = 5'd12; wdata[W-1:0] = 32'h77;
    tick();
    clr = 1'b0;
    waddr[AW-1:0] = 5'd9; wdata[W-1:0] = 32'hEE;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_busy: got %b, need 1", busy);
    end
    tick();
    n_checks++;
    if (rdata[W-1:0] !== '0) begin
      n_fail++;
      $display("FAIL clr_rdata_zero: got %h, need 0", rdata[W-1:0]);
    end
    wait_busy_low(n);
    wen = 2'b00;
    n_checks++;
    if (n + 1 !== 32) begin
      n_fail++;
      $display("FAIL clr_busy_len: %0d cycles, need 32", n + 1);
    end
    read0(5'd9, d);
    n_checks++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL clr_reg9: got %h, need 0", d);
    end
    read0(5'd12, d);
    n_checks++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL clr_reg12: got %h, need 0", d);
    end
  endtask

  task automatic test_saturate();
    wen = 2'b11; waddr = {5'd20, 5'd20}; wdata = {32'h2, 32'h1};
    for (int i = 0; i < 250; i++) tick();
    n_checks++;
    if (conflict_cnt !== 8'd251) begin
      n_fail++;
      $display("FAIL sat_mid: got %0d, need 251", conflict_cnt);
    end
    for (int i = 0; i < 50; i++) tick();
    wen = 2'b00;
    n_checks++;
    if (conflict_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_final: got %0d, need 255", conflict_cnt);
    end
  endtask

  task automatic test_rst_midseq();
    int n;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (conflict_cnt !== 8'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_state: cnt=%0d busy=%b, need cnt=0 busy=1", conflict_cnt, busy);
    end
    tick();
    rst = 1'b0;
    wait_busy_low(n);
    n_checks++;
    if (n !== 32) begin
      n_fail++;
      $display("FAIL midrst_busy_len: %0d cycles, need 32", n);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_bypass();
    test_stall();
    test_clk_en();
    test_r0();
    test_clr();
    test_saturate();
    test_rst_midseq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, need completion");
    $fatal(1);
  end
endmodule
